// File: rtl/id_ex_if.sv
// Decode-side inputs and EX-side outputs of the ID/EX pipeline register.
// The slave modport faces the stage; the master modport faces the decoder/EX driver.
interface id_ex_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              valid_i;
   logic              RegWrite_i, ALUSrc_i, RegDst_i, Branch_i;
   logic              MemRead_i, MemWrite_i, MemToReg_i;
   logic [2:0]        ALU_op_i;
   logic              reads_rt_i;
   logic [4:0]        rs_addr_i, rt_addr_i, rd_addr_i;
   logic [DATA_W-1:0] rs_data_i, rt_data_i, imm_ext_i, pc4_i;
   logic              flush_i, hold_i;

   logic              valid_o;
   logic              RegWrite_o, ALUSrc_o, RegDst_o, Branch_o;
   logic              MemRead_o, MemWrite_o, MemToReg_o;
   logic [2:0]        ALU_op_o;
   logic [4:0]        rs_addr_o, rt_addr_o, rd_addr_o;
   logic [DATA_W-1:0] rs_data_o, rt_data_o, imm_ext_o, pc4_o;
   logic              stall_o;
   logic [CNT_W-1:0]  bubble_cnt_o;

   modport slave (
      input  valid_i, RegWrite_i, ALUSrc_i, RegDst_i, Branch_i, MemRead_i, MemWrite_i,
             MemToReg_i, ALU_op_i, reads_rt_i, rs_addr_i, rt_addr_i, rd_addr_i,
             rs_data_i, rt_data_i, imm_ext_i, pc4_i, flush_i, hold_i,
      output valid_o, RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, MemRead_o, MemWrite_o,
             MemToReg_o, ALU_op_o, rs_addr_o, rt_addr_o, rd_addr_o,
             rs_data_o, rt_data_o, imm_ext_o, pc4_o, stall_o, bubble_cnt_o
   );

   modport master (
      output valid_i, RegWrite_i, ALUSrc_i, RegDst_i, Branch_i, MemRead_i, MemWrite_i,
             MemToReg_i, ALU_op_i, reads_rt_i, rs_addr_i, rt_addr_i, rd_addr_i,
             rs_data_i, rt_data_i, imm_ext_i, pc4_i, flush_i, hold_i,
      input  valid_o, RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, MemRead_o, MemWrite_o,
             MemToReg_o, ALU_op_o, rs_addr_o, rt_addr_o, rd_addr_o,
             rs_data_o, rt_data_o, imm_ext_o, pc4_o, stall_o, bubble_cnt_o
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic     clk_i,
   input  logic     rst_i,
   id_ex_if.slave   bus
);
   localparam int CTRL_W = 10;
   localparam int BASE   = 4 * DATA_W;
   localparam int OPND_W = BASE + 15;
   localparam int RW_B = 9, AS_B = 8, RD_B = 7, BR_B = 6, MR_B = 5, MW_B = 4, MT_B = 3;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d, ctrl_in_s;
   logic [OPND_W-1:0] opnd_q, opnd_d, opnd_in_s;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [4:0]        ex_rt_s;
   logic              haz_s;

   assign ctrl_in_s = {bus.RegWrite_i, bus.ALUSrc_i, bus.RegDst_i, bus.Branch_i,
                       bus.MemRead_i, bus.MemWrite_i, bus.MemToReg_i, bus.ALU_op_i};
   assign opnd_in_s = {bus.rs_addr_i, bus.rt_addr_i, bus.rd_addr_i,
                       bus.rs_data_i, bus.rt_data_i, bus.imm_ext_i, bus.pc4_i};
   assign ex_rt_s   = opnd_q[BASE+9:BASE+5];

   // A load in EX whose destination is read by the decode instruction must wait one cycle
   assign haz_s = valid_q & ctrl_q[MR_B] & (ex_rt_s != 5'd0) & bus.valid_i &
                  ((bus.rs_addr_i == ex_rt_s) | (bus.reads_rt_i & (bus.rt_addr_i == ex_rt_s)));
   assign bus.stall_o = haz_s & ~bus.flush_i & ~bus.hold_i & ~rst_i;

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      opnd_d  = opnd_q;
      cnt_d   = cnt_q;
      if (bus.flush_i) begin
         valid_d = 1'b0;
         ctrl_d  = {CTRL_W{1'b0}};
         opnd_d  = opnd_in_s;
      end else if (bus.hold_i) begin
         valid_d = valid_q;
      end else if (haz_s) begin
         valid_d = 1'b0;
         ctrl_d  = {CTRL_W{1'b0}};
         opnd_d  = opnd_in_s;
         cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end else begin
         valid_d = bus.valid_i;
         ctrl_d  = bus.valid_i ? ctrl_in_s : {CTRL_W{1'b0}};
         opnd_d  = opnd_in_s;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         ctrl_q  <= {CTRL_W{1'b0}};
         opnd_q  <= {OPND_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.valid_o      = valid_q;
   assign bus.RegWrite_o   = ctrl_q[RW_B];
   assign bus.ALUSrc_o     = ctrl_q[AS_B];
   assign bus.RegDst_o     = ctrl_q[RD_B];
   assign bus.Branch_o     = ctrl_q[BR_B];
   assign bus.MemRead_o    = ctrl_q[MR_B];
   assign bus.MemWrite_o   = ctrl_q[MW_B];
   assign bus.MemToReg_o   = ctrl_q[MT_B];
   assign bus.ALU_op_o     = ctrl_q[2:0];
   assign bus.rs_addr_o    = opnd_q[BASE+14:BASE+10];
   assign bus.rt_addr_o    = ex_rt_s;
   assign bus.rd_addr_o    = opnd_q[BASE+4:BASE];
   assign bus.rs_data_o    = opnd_q[4*DATA_W-1:3*DATA_W];
   assign bus.rt_data_o    = opnd_q[3*DATA_W-1:2*DATA_W];
   assign bus.imm_ext_o    = opnd_q[2*DATA_W-1:DATA_W];
   assign bus.pc4_o        = opnd_q[DATA_W-1:0];
   assign bus.bubble_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against an instruction-level model.
// The counter is built 8 bits wide so saturation is reachable in a short run.
module tb_id_ex_stage;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 8;
   localparam int CMAX   = 255;

   typedef struct packed {
      logic        valid;
      logic        rw, alusrc, regdst, branch, memread, memwrite, memtoreg;
      logic [2:0]  op;
      logic        reads_rt;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rsd, rtd, imm, pc4;
   } ins_t;

   logic clk;
   logic rst;
   id_ex_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
   id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   vectors = 0;
   int   miscompares = 0;
   bit   chk_en = 1'b0;
   ins_t m_ex;
   int   m_cnt;
   ins_t cur_id;
   bit   cur_fl, cur_hd;
   logic last_stall;

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic ins_t mk(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd);
      ins_t x = '0;
      x.valid = 1'b1;
      x.rs = rs; x.rt = rt; x.rd = rd;
      x.rsd = $urandom; x.rtd = $urandom; x.imm = $urandom; x.pc4 = $urandom & 32'hFFFF_FFFC;
      case (kind)
         0: begin x.op = 3'd0; x.regdst = 1'b1; x.rw = 1'b1; x.reads_rt = 1'b1; end
         1: begin x.op = 3'd1; x.alusrc = 1'b1; x.rw = 1'b1; end
         2: begin x.op = 3'd7; x.alusrc = 1'b1; x.rw = 1'b1; x.memread = 1'b1; x.memtoreg = 1'b1; end
         3: begin x.op = 3'd7; x.alusrc = 1'b1; x.memwrite = 1'b1; x.reads_rt = 1'b1; end
         default: begin x.op = 3'd2; x.branch = 1'b1; x.reads_rt = 1'b1; end
      endcase
      return x;
   endfunction

   function automatic ins_t bubble(input ins_t x);
      ins_t b = x;
      b.valid = 1'b0; b.rw = 1'b0; b.alusrc = 1'b0; b.regdst = 1'b0; b.branch = 1'b0;
      b.memread = 1'b0; b.memwrite = 1'b0; b.memtoreg = 1'b0; b.op = 3'd0;
      return b;
   endfunction

   // A load in EX blocks a decode instruction that reads its (non-zero) destination
   function automatic bit model_haz(input ins_t id);
      return m_ex.valid && m_ex.memread && (m_ex.rt != 5'd0) && id.valid &&
             ((id.rs == m_ex.rt) || (id.reads_rt && (id.rt == m_ex.rt)));
   endfunction

   task automatic drive(input ins_t id, input bit fl, input bit hd);
      cur_id = id; cur_fl = fl; cur_hd = hd;
      bus.valid_i = id.valid; bus.RegWrite_i = id.rw; bus.ALUSrc_i = id.alusrc;
      bus.RegDst_i = id.regdst; bus.Branch_i = id.branch; bus.MemRead_i = id.memread;
      bus.MemWrite_i = id.memwrite; bus.MemToReg_i = id.memtoreg; bus.ALU_op_i = id.op;
      bus.reads_rt_i = id.reads_rt; bus.rs_addr_i = id.rs; bus.rt_addr_i = id.rt;
      bus.rd_addr_i = id.rd; bus.rs_data_i = id.rsd; bus.rt_data_i = id.rtd;
      bus.imm_ext_i = id.imm; bus.pc4_i = id.pc4; bus.flush_i = fl; bus.hold_i = hd;
   endtask

   task automatic step(input ins_t id, input bit fl, input bit hd);
      drive(id, fl, hd);
      #4;
      last_stall = bus.stall_o;
      @(posedge clk);
      if (cur_fl) begin
         m_ex = bubble(cur_id);
      end else if (cur_hd) begin
         m_ex = m_ex;
      end else if (model_haz(cur_id)) begin
         m_ex = bubble(cur_id);
         if (m_cnt < CMAX) m_cnt++;
      end else begin
         m_ex = cur_id.valid ? cur_id : bubble(cur_id);
      end
      #1;
   endtask

   // Every cycle: compare the EX slot, stall and counter with the model
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("stall", bus.stall_o, model_haz(cur_id) && !cur_fl && !cur_hd);
         cmp("valid", bus.valid_o, m_ex.valid);
         cmp("cnt", bus.bubble_cnt_o, m_cnt);
         cmp("ctrl", {bus.RegWrite_o, bus.ALUSrc_o, bus.RegDst_o, bus.Branch_o, bus.MemRead_o,
                      bus.MemWrite_o, bus.MemToReg_o, bus.ALU_op_o},
                     {m_ex.rw, m_ex.alusrc, m_ex.regdst, m_ex.branch, m_ex.memread,
                      m_ex.memwrite, m_ex.memtoreg, m_ex.op});
         if (m_ex.valid) begin
            cmp("addr", {bus.rs_addr_o, bus.rt_addr_o, bus.rd_addr_o}, {m_ex.rs, m_ex.rt, m_ex.rd});
            cmp("rsrt", {bus.rs_data_o, bus.rt_data_o}, {m_ex.rsd, m_ex.rtd});
            cmp("immpc", {bus.imm_ext_o, bus.pc4_o}, {m_ex.imm, m_ex.pc4});
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      ins_t idle, a, b;
      idle = '0;
      m_ex = '0; m_cnt = 0;
      rst = 1'b1;
      drive(idle, 1'b0, 1'b0);
      #3;
      cmp("rst_valid", bus.valid_o, 1'b0);
      cmp("rst_cnt", bus.bubble_cnt_o, 8'h00);
      cmp("rst_stall", bus.stall_o, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;
      step(idle, 1'b0, 1'b0);
      cmp("idle_valid", bus.valid_o, 1'b0);

      a = mk(1, 5'd1, 5'd5, 5'd0); a.imm = 32'h0000_FFF0; a.pc4 = 32'h0000_0104;
      step(a, 1'b0, 1'b0);
      cmp("addi_valid", bus.valid_o, 1'b1);
      cmp("addi_op", {bus.ALU_op_o, bus.ALUSrc_o, bus.RegWrite_o}, 5'b001_1_1);
      cmp("addi_rt", bus.rt_addr_o, 5'd5);
      cmp("addi_imm", bus.imm_ext_o, 32'h0000_FFF0);
      cmp("addi_pc4", bus.pc4_o, 32'h0000_0104);

      // load-use on rs
      step(mk(2, 5'd1, 5'd8, 5'd0), 1'b0, 1'b0);
      b = mk(0, 5'd8, 5'd9, 5'd10);
      step(b, 1'b0, 1'b0);
      cmp("lu_stall", last_stall, 1'b1);
      cmp("lu_bubble", {bus.valid_o, bus.RegWrite_o}, 2'b00);
      step(b, 1'b0, 1'b0);
      cmp("lu_stall2", last_stall, 1'b0);
      cmp("lu_add", {bus.valid_o, bus.rd_addr_o}, {1'b1, 5'd10});
      cmp("lu_cnt", bus.bubble_cnt_o, 8'd1);

      // rt dependency gating and $0
      step(mk(2, 5'd1, 5'd8, 5'd0), 1'b0, 1'b0);
      b = mk(3, 5'd1, 5'd8, 5'd0);
      step(b, 1'b0, 1'b0);
      cmp("sw_stall", last_stall, 1'b1);
      step(b, 1'b0, 1'b0);
      step(mk(2, 5'd1, 5'd8, 5'd0), 1'b0, 1'b0);
      step(mk(1, 5'd1, 5'd8, 5'd0), 1'b0, 1'b0);
      cmp("addi_nostall", last_stall, 1'b0);
      step(mk(2, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0);
      step(mk(0, 5'd0, 5'd2, 5'd3), 1'b0, 1'b0);
      cmp("r0_nostall", last_stall, 1'b0);

      // flush beats hazard
      step(mk(2, 5'd1, 5'd8, 5'd0), 1'b0, 1'b0);
      step(mk(0, 5'd8, 5'd9, 5'd10), 1'b1, 1'b0);
      cmp("fl_stall", last_stall, 1'b0);
      cmp("fl_valid", bus.valid_o, 1'b0);
      cmp("fl_cnt", bus.bubble_cnt_o, 8'd2);

      // hold during a hazard, then the stall happens once
      step(mk(2, 5'd1, 5'd8, 5'd0), 1'b0, 1'b0);
      b = mk(0, 5'd8, 5'd9, 5'd10);
      for (int i = 0; i < 3; i++) begin
         step(b, 1'b0, 1'b1);
         cmp("hd_stall", last_stall, 1'b0);
         cmp("hd_frozen", {bus.valid_o, bus.MemRead_o, bus.rt_addr_o}, {1'b1, 1'b1, 5'd8});
         cmp("hd_cnt", bus.bubble_cnt_o, 8'd2);
      end
      step(b, 1'b0, 1'b0);
      cmp("hd_release_stall", last_stall, 1'b1);
      cmp("hd_release_cnt", bus.bubble_cnt_o, 8'd3);
      step(b, 1'b0, 1'b0);

      // saturation
      for (int i = 0; i < 300; i++) begin
         step(mk(2, 5'd1, 5'd8, 5'd0), 1'b0, 1'b0);
         b = mk(0, 5'd8, 5'd9, 5'd10);
         step(b, 1'b0, 1'b0);
         step(b, 1'b0, 1'b0);
      end
      cmp("sat_cnt", bus.bubble_cnt_o, 8'hFF);

      // reset asserted while stalling
      step(mk(2, 5'd1, 5'd8, 5'd0), 1'b0, 1'b0);
      drive(mk(0, 5'd8, 5'd9, 5'd10), 1'b0, 1'b0);
      #4;
      cmp("pre_rst_stall", bus.stall_o, 1'b1);
      #1 rst = 1'b1;
      chk_en = 1'b0;
      #1;
      cmp("mid_rst_stall", bus.stall_o, 1'b0);
      cmp("mid_rst_valid", bus.valid_o, 1'b0);
      cmp("mid_rst_cnt", bus.bubble_cnt_o, 8'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_ex = '0; m_cnt = 0;
      chk_en = 1'b1;

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] regs [4];
         regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd2; regs[3] = 5'd8;
         a = mk(int'($urandom_range(0, 4)), regs[$urandom_range(0, 3)],
                regs[$urandom_range(0, 3)], 5'($urandom_range(0, 31)));
         a.valid = ($urandom_range(0, 7) != 0);
         step(a, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
